// File: rtl/ysyx_23060203_ibuf.sv
// Instruction buffer between fetch and decode: a small circular FIFO of
// {pc, inst} pairs, each annotated at enqueue with predecode and static-prediction bits.
module ysyx_23060203_ibuf #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic             out_pred_taken,
    output logic [31:0]      out_pred_npc,
    output logic             out_is_ctrl,
    output logic [PTR_W:0]   out_count
);

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] inst_mem  [DEPTH];
    logic [31:0] npc_mem   [DEPTH];
    logic        taken_mem [DEPTH];
    logic        ctrl_mem  [DEPTH];

    logic [4:0]  opcode;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic        pd_is_jal;
    logic        pd_is_branch;
    logic        pd_taken;
    logic        pd_ctrl;
    logic [31:0] pd_npc;

    logic push;
    logic pop;

    // Predecode of the incoming word; fetch predicted backward branches and JAL as taken
    assign opcode       = in_inst[6:2];
    assign imm_b        = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_j        = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign pd_is_jal    = (opcode == OP_JAL);
    assign pd_is_branch = (opcode == OP_BRANCH);
    assign pd_taken     = pd_is_jal | (pd_is_branch & in_inst[31]);
    assign pd_ctrl      = pd_is_jal | pd_is_branch | (opcode == OP_JALR);
    assign pd_npc       = in_pc + (pd_is_jal ? imm_j : (pd_taken ? imm_b : 32'd4));

    assign in_ready  = (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0) & ~flush;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;
    assign out_count = count_reg;

    assign out_pc         = pc_mem[rd_ptr_reg];
    assign out_inst       = inst_mem[rd_ptr_reg];
    assign out_pred_npc   = npc_mem[rd_ptr_reg];
    assign out_pred_taken = taken_mem[rd_ptr_reg];
    assign out_is_ctrl    = ctrl_mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (PTR_W+1)'(1);
            2'b01:   count_next = count_reg - (PTR_W+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    // Entry storage carries no reset; contents are only observed while out_valid is high
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= in_pc;
            inst_mem[wr_ptr_reg]  <= in_inst;
            npc_mem[wr_ptr_reg]   <= pd_npc;
            taken_mem[wr_ptr_reg] <= pd_taken;
            ctrl_mem[wr_ptr_reg]  <= pd_ctrl;
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_ibuf.sv
// Randomized and directed checks of ysyx_23060203_ibuf against a queue-based model
// that derives predecode results from the RV32 immediate field definitions.
module tb_ysyx_23060203_ibuf;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_pred_taken;
    logic [31:0] out_pred_npc;
    logic        out_is_ctrl;
    logic [2:0]  out_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t q[$];
    int vectors = 0;
    int miscompares = 0;

    ysyx_23060203_ibuf #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_pred_taken(out_pred_taken), .out_pred_npc(out_pred_npc),
        .out_is_ctrl(out_is_ctrl), .out_count(out_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [31:0] inst);
        return (inst[6:2] == 5'b11011) || (inst[6:2] == 5'b11000 && inst[31]);
    endfunction

    function automatic logic ref_ctrl(input logic [31:0] inst);
        return (inst[6:2] == 5'b11011) || (inst[6:2] == 5'b11000) || (inst[6:2] == 5'b11001);
    endfunction

    // Immediates assembled field by field with shifts/masks; sign applied by subtracting 2^N
    function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [31:0] inst);
        logic [31:0] imm;
        if (inst[6:2] == 5'b11011) begin
            imm = ((inst >> 21) & 32'h3FF) * 2 + ((inst >> 20) & 32'h1) * 2048
                + ((inst >> 12) & 32'hFF) * 4096;
            if (inst[31]) imm = imm - 32'h0010_0000;
        end else if (inst[6:2] == 5'b11000 && inst[31]) begin
            imm = ((inst >> 8) & 32'hF) * 2 + ((inst >> 25) & 32'h3F) * 32
                + ((inst >> 7) & 32'h1) * 2048 - 32'h1000;
        end else begin
            imm = 32'd4;
        end
        return pc + imm;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0] op;
        case ($urandom_range(0, 3))
            0: op = 5'b11000;
            1: op = 5'b11011;
            2: op = 5'b11001;
            default: op = 5'b00100;
        endcase
        return ($urandom & 32'hFFFF_FF80) | {25'd0, op, 2'b11};
    endfunction

    task automatic check_outputs();
        logic exp_valid;
        exp_valid = (q.size() != 0) && !flush;
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() != DEPTH});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        chk("out_count", {29'd0, out_count}, 32'(q.size()));
        if (exp_valid) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_inst", out_inst, q[0].inst);
            chk("out_pred_taken", {31'd0, out_pred_taken}, {31'd0, ref_taken(q[0].inst)});
            chk("out_pred_npc", out_pred_npc, ref_npc(q[0].pc, q[0].inst));
            chk("out_is_ctrl", {31'd0, out_is_ctrl}, {31'd0, ref_ctrl(q[0].inst)});
        end
    endtask

    // One clock: drive, check at the falling edge, advance the model, land at posedge+1
    task automatic step(input logic f, input logic iv, input logic [31:0] pc,
                        input logic [31:0] inst, input logic ordy);
        logic do_pop;
        logic do_push;
        flush = f; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
        @(negedge clock);
        check_outputs();
        if (f) begin
            q.delete();
        end else begin
            do_pop  = (q.size() != 0) && ordy;
            do_push = iv && (q.size() != DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{pc: pc, inst: inst});
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] pc_seq;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        #3;
        check_outputs();
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Fill to full, then a refused push, then full+pop+push refused, then drain
        for (int i = 0; i < 4; i++) step(0, 1, 32'h8000_0000 + 32'(i * 4), 32'h0000_0013, 0);
        chk("full_count", {29'd0, out_count}, 32'd4);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        step(0, 1, 32'h8000_0010, 32'h0000_0013, 0);
        step(0, 1, 32'h8000_0014, 32'h0000_0013, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 32'h0, 1);

        // Concurrent push/pop at occupancy 2 across pointer wrap
        pc_seq = 32'h8000_1000;
        for (int i = 0; i < 2; i++) begin
            step(0, 1, pc_seq, rand_inst(), 0);
            pc_seq += 4;
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 1, pc_seq, rand_inst(), 1);
            pc_seq += 4;
        end
        chk("steady_count", {29'd0, out_count}, 32'd2);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Directed predecode vectors
        step(0, 1, 32'h8000_0010, 32'hFE00_0EE3, 0);
        step(0, 1, 32'h8000_0000, 32'h0080_006F, 0);
        step(0, 1, 32'h8000_0040, 32'h0000_8067, 0);
        chk("beq_taken", {31'd0, out_pred_taken}, 32'd1);
        chk("beq_npc", out_pred_npc, 32'h8000_000C);
        step(0, 0, 0, 0, 1);
        chk("jal_npc", out_pred_npc, 32'h8000_0008);
        step(0, 0, 0, 0, 1);
        chk("jalr_ctrl", {31'd0, out_is_ctrl}, 32'd1);
        chk("jalr_taken", {31'd0, out_pred_taken}, 32'd0);
        chk("jalr_npc", out_pred_npc, 32'h8000_0044);
        step(0, 0, 0, 0, 1);

        // Flush at occupancy 3 with a simultaneous incoming instruction
        for (int i = 0; i < 3; i++) step(0, 1, 32'h8000_2000 + 32'(i * 4), rand_inst(), 0);
        step(1, 1, 32'hDEAD_0000, 32'h0000_0013, 1);
        chk("flush_count", {29'd0, out_count}, 32'd0);
        step(1, 0, 0, 0, 1);
        step(1, 1, 32'hDEAD_0004, 32'h0000_0013, 1);
        step(0, 1, 32'h8000_3000, 32'h0000_0013, 0);
        chk("post_flush_pc", out_pc, 32'h8000_3000);
        step(0, 0, 0, 0, 1);

        // PC wrap in the sequential-npc adder
        step(0, 1, 32'hFFFF_FFFC, 32'h0000_0013, 0);
        chk("wrap_npc", out_pred_npc, 32'h0000_0000);
        step(0, 0, 0, 0, 1);

        // Asynchronous reset between clock edges with two entries queued
        step(0, 1, 32'h8000_4000, rand_inst(), 0);
        step(0, 1, 32'h8000_4004, rand_inst(), 0);
        in_valid = 1'b0; out_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("areset_valid", {31'd0, out_valid}, 32'd0);
        chk("areset_count", {29'd0, out_count}, 32'd0);
        q.delete();
        #1 reset = 1'b0;
        step(0, 0, 0, 0, 0);

        // Random traffic with occasional flushes
        pc_seq = 32'h8001_0000;
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, pc_seq, rand_inst(),
                 $urandom_range(0, 2) != 0);
            pc_seq += 4;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
